// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants for the synchronous FIFO controller that drives the
// 16x16 dual-port asynchronous RAM.
//   - Default word and address widths, and the derived depth.
//   - Fixed control levels for the RAM pins that never change (port 0 output
//     enable, and the port 1 chip select, write enable and output enable).
// Optional feature macro used by the controller: SYNC_FIFO_ERR_EN
// (adds sticky overflow/underflow flags and an err_clr input).
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Port 0 is write-only, so its output driver is never enabled.
    localparam logic RAM_OE_0_LVL = 1'b0;

    // Port 1 is a permanently selected, read-only port.
    localparam logic RAM_CS_1_LVL = 1'b1;
    localparam logic RAM_WE_1_LVL = 1'b0;
    localparam logic RAM_OE_1_LVL = 1'b1;

    // Depth of a RAM with the given address width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// -----------------------------------------------------------------------------
// sync_fifo_ptr
// ADDR_W-bit address pointer that advances by one when enabled. It wraps
// from DEPTH-1 back to 0 through natural overflow of the power-of-two width.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (pointer returns to 0)
//   en     in   advance the pointer at the next edge
//   ptr    out  current pointer value (registered)
// -----------------------------------------------------------------------------
module sync_fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Controller for the 16x16 dual-port asynchronous RAM used as the filter's
// synchronous FIFO. Port 0 of the RAM is written only, port 1 is read only.
// The controller owns the pointers, occupancy level and flags, and offers a
// push/pop interface. RAM port 0 control, address and data are registered so
// the RAM sees glitch-free cs/we.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   push, push_data, full write side; a push is taken when !full
//   pop, pop_data,
//   pop_valid, empty      read side; pop_data/pop_valid arrive one cycle
//                         after an accepted pop
//   level                 occupancy 0..DEPTH, counts the in-flight write
//   ram_*_0               RAM port 0 (write-only)
//   ram_*_1               RAM port 1 (read-only, address = read pointer)
//
// Optional feature macro SYNC_FIFO_ERR_EN adds:
//   err_clr   in   clears both sticky error flags (clear beats set)
//   overflow  out  sticky, set by push while full
//   underflow out  sticky, set by pop while empty
// -----------------------------------------------------------------------------
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W-1:0] ram_address_0,
    output logic [DATA_W-1:0] ram_data_0,
    output logic              ram_cs_0,
    output logic              ram_we_0,
    output logic              ram_oe_0,
    output logic [ADDR_W-1:0] ram_address_1,
    input  logic [DATA_W-1:0] ram_data_1,
    output logic              ram_cs_1,
    output logic              ram_we_1,
    output logic              ram_oe_1
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int unsigned      DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  FULL_LEVEL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic [ADDR_W:0]   level_q,         level_d;
    logic [ADDR_W-1:0] ram_address_0_q, ram_address_0_d;
    logic [DATA_W-1:0] ram_data_0_q,    ram_data_0_d;
    logic              ram_we_0_q,      ram_we_0_d;
    logic [DATA_W-1:0] pop_data_q,      pop_data_d;
    logic              pop_valid_q,     pop_valid_d;

    logic              acc_w;
    logic              acc_r;
    logic [ADDR_W:0]   committed;

    // Flags come only from registered state. The word currently being
    // written (we high) is counted in level but cannot be read yet, so
    // empty is judged on the committed count.
    assign committed = level_q - (ADDR_W+1)'(ram_we_0_q);
    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (committed == '0);

    // Both accepts use the flags as they stand before this edge, so a
    // same-cycle pop never frees room for a push at full and a same-cycle
    // push never supplies data for a pop at empty.
    assign acc_w = push && !full;
    assign acc_r = pop && !empty;

    sync_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc_w),
        .ptr   (wr_ptr)
    );

    sync_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc_r),
        .ptr   (rd_ptr)
    );

    // Next-state for the level, the port 0 write cycle and the read result.
    // Port 0 address/data hold when idle; only we drops.
    always_comb begin
        level_d         = level_q + (ADDR_W+1)'(acc_w) - (ADDR_W+1)'(acc_r);
        ram_address_0_d = ram_address_0_q;
        ram_data_0_d    = ram_data_0_q;
        ram_we_0_d      = 1'b0;
        pop_data_d      = pop_data_q;
        pop_valid_d     = acc_r;
        if (acc_w) begin
            ram_address_0_d = wr_ptr;
            ram_data_0_d    = push_data;
            ram_we_0_d      = 1'b1;
        end
        if (acc_r) begin
            pop_data_d = ram_data_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q         <= '0;
            ram_address_0_q <= '0;
            ram_data_0_q    <= '0;
            ram_we_0_q      <= 1'b0;
            pop_data_q      <= '0;
            pop_valid_q     <= 1'b0;
        end else begin
            level_q         <= level_d;
            ram_address_0_q <= ram_address_0_d;
            ram_data_0_q    <= ram_data_0_d;
            ram_we_0_q      <= ram_we_0_d;
            pop_data_q      <= pop_data_d;
            pop_valid_q     <= pop_valid_d;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags record requests that were refused.
    always_comb begin
        overflow_d  = overflow_q  | (push && full);
        underflow_d = underflow_q | (pop && empty);
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign level         = level_q;
    assign pop_data      = pop_data_q;
    assign pop_valid     = pop_valid_q;

    // Chip select and write enable share one flop: port 0 is selected only
    // to write.
    assign ram_address_0 = ram_address_0_q;
    assign ram_data_0    = ram_data_0_q;
    assign ram_cs_0      = ram_we_0_q;
    assign ram_we_0      = ram_we_0_q;
    assign ram_oe_0      = RAM_OE_0_LVL;

    assign ram_address_1 = rd_ptr;
    assign ram_cs_1      = RAM_CS_1_LVL;
    assign ram_we_1      = RAM_WE_1_LVL;
    assign ram_oe_1      = RAM_OE_1_LVL;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Self-checking bench for sync_fifo_ctrl with a behavioural model of the
// dual-port RAM. Expected behaviour comes from a queue-based FIFO model:
// the queue holds every accepted word, the newest of which is not yet
// readable during the cycle its write is in progress.
// Optional feature macro SYNC_FIFO_ERR_EN enables the sticky flag checks.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        push;
    logic [15:0] push_data;
    logic        full;
    logic        pop;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic        empty;
    logic [4:0]  level;
    logic [3:0]  ram_address_0;
    logic [15:0] ram_data_0;
    logic        ram_cs_0;
    logic        ram_we_0;
    logic        ram_oe_0;
    logic [3:0]  ram_address_1;
    logic [15:0] ram_data_1;
    logic        ram_cs_1;
    logic        ram_we_1;
    logic        ram_oe_1;
`ifdef SYNC_FIFO_ERR_EN
    logic        err_clr;
    logic        overflow;
    logic        underflow;
`endif

    int checks;
    int errors;

    // Reference model state.
    logic [15:0] mq[$];
    bit          m_pend;
    bit          m_pv;
    logic [15:0] m_pd;
    logic [3:0]  m_addr;
    logic [15:0] m_wdata;
    int          m_wr;
    int          m_rd;
`ifdef SYNC_FIFO_ERR_EN
    bit          m_ovf;
    bit          m_udf;
`endif

    typedef struct {
        logic        push;
        logic        pop;
        logic [15:0] data;
        int          lvl;
        logic        emp;
        logic        ful;
        logic        we;
        logic        pv;
        logic [15:0] pd;
    } vec_t;

    vec_t vecs[10];

    sync_fifo_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_data     (push_data),
        .full          (full),
        .pop           (pop),
        .pop_data      (pop_data),
        .pop_valid     (pop_valid),
        .empty         (empty),
        .level         (level),
        .ram_address_0 (ram_address_0),
        .ram_data_0    (ram_data_0),
        .ram_cs_0      (ram_cs_0),
        .ram_we_0      (ram_we_0),
        .ram_oe_0      (ram_oe_0),
        .ram_address_1 (ram_address_1),
        .ram_data_1    (ram_data_1),
        .ram_cs_1      (ram_cs_1),
        .ram_we_1      (ram_we_1),
        .ram_oe_1      (ram_oe_1)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr       (err_clr),
        .overflow      (overflow),
        .underflow     (underflow)
`endif
    );

    // Behavioural RAM: a write cycle completes at the end of the cycle in
    // which cs/we are high; reads are combinational.
    logic [15:0] mem [16];

    always @(posedge clk) begin
        if (ram_cs_0 && ram_we_0) begin
            mem[ram_address_0] <= ram_data_0;
        end
    end

    assign ram_data_1 = mem[ram_address_1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_pend  = 1'b0;
        m_pv    = 1'b0;
        m_pd    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wr    = 0;
        m_rd    = 0;
`ifdef SYNC_FIFO_ERR_EN
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
`endif
    endtask

    // Drives one cycle of requests, advances the model with the FIFO rules,
    // then lets the clock edge pass and returns 1 time unit after it.
    task automatic applyStimulus(input logic p, input logic [15:0] d, input logic r);
        bit aw;
        bit ar;
        push      = p;
        push_data = d;
        pop       = r;
        aw = p && (mq.size() < 16);
        ar = r && ((mq.size() - int'(m_pend)) > 0);
`ifdef SYNC_FIFO_ERR_EN
        if (p && !aw) m_ovf = 1'b1;
        if (r && !ar) m_udf = 1'b1;
`endif
        m_pv = ar;
        if (ar) begin
            m_pd = mq.pop_front();
            m_rd++;
        end
        if (aw) begin
            mq.push_back(d);
            m_addr  = 4'(m_wr % 16);
            m_wdata = d;
            m_wr++;
        end
        m_pend = aw;
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_level"},  32'(level),         32'(mq.size()));
        checkOutput({tag, "_full"},   32'(full),          32'(mq.size() == 16));
        checkOutput({tag, "_empty"},  32'(empty),         32'((mq.size() - int'(m_pend)) == 0));
        checkOutput({tag, "_pv"},     32'(pop_valid),     32'(m_pv));
        checkOutput({tag, "_pd"},     32'(pop_data),      32'(m_pd));
        checkOutput({tag, "_we"},     32'(ram_we_0),      32'(m_pend));
        checkOutput({tag, "_cs"},     32'(ram_cs_0),      32'(m_pend));
        checkOutput({tag, "_waddr"},  32'(ram_address_0), 32'(m_addr));
        checkOutput({tag, "_wdata"},  32'(ram_data_0),    32'(m_wdata));
        checkOutput({tag, "_raddr"},  32'(ram_address_1), 32'(m_rd % 16));
`ifdef SYNC_FIFO_ERR_EN
        checkOutput({tag, "_ovf"},    32'(overflow),      32'(m_ovf));
        checkOutput({tag, "_udf"},    32'(underflow),     32'(m_udf));
`endif
    endtask

    task automatic drainAll(input string tag);
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
            checkModel(tag);
        end
        checkOutput({tag, "_drained"}, 32'(mq.size()), 32'd0);
    endtask

    initial begin
        int pushed;
        int cyc;
        checks    = 0;
        errors    = 0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
`ifdef SYNC_FIFO_ERR_EN
        err_clr   = 1'b0;
`endif
        modelReset();

        // Directed vectors from a clean reset.
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 16'hAAAA, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234};
        vecs[6] = '{1'b1, 1'b1, 16'hBBBB, 2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA};
        vecs[8] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBBBB};
        vecs[9] = '{1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBBBB};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset and idle");
        checkOutput("tie_oe0", 32'(ram_oe_0), 32'd0);
        checkOutput("tie_cs1", 32'(ram_cs_1), 32'd1);
        checkOutput("tie_we1", 32'(ram_we_1), 32'd0);
        checkOutput("tie_oe1", 32'(ram_oe_1), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
            checkOutput("idle_level", 32'(level),     32'd0);
            checkOutput("idle_empty", 32'(empty),     32'd1);
            checkOutput("idle_full",  32'(full),      32'd0);
            checkOutput("idle_we",    32'(ram_we_0),  32'd0);
            checkOutput("idle_pv",    32'(pop_valid), 32'd0);
        end

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].push, vecs[i].data, vecs[i].pop);
            checkOutput($sformatf("vec%0d_level", i), 32'(level),     32'(vecs[i].lvl));
            checkOutput($sformatf("vec%0d_empty", i), 32'(empty),     32'(vecs[i].emp));
            checkOutput($sformatf("vec%0d_full", i),  32'(full),      32'(vecs[i].ful));
            checkOutput($sformatf("vec%0d_we", i),    32'(ram_we_0),  32'(vecs[i].we));
            checkOutput($sformatf("vec%0d_pv", i),    32'(pop_valid), 32'(vecs[i].pv));
            checkOutput($sformatf("vec%0d_pd", i),    32'(pop_data),  32'(vecs[i].pd));
            if (vecs[i].we) begin
                checkOutput($sformatf("vec%0d_wdata", i), 32'(ram_data_0), 32'(vecs[i].data));
            end
            checkModel($sformatf("vec%0d_model", i));
        end

        $display("[TB] fill, overflow and drain");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0);
            checkModel("fill");
        end
        checkOutput("fill_full",  32'(full),  32'd1);
        checkOutput("fill_level", 32'(level), 32'd16);
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        checkOutput("ovf_level", 32'(level),    32'd16);
        checkOutput("ovf_we",    32'(ram_we_0), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
        checkOutput("ovf_flag",  32'(overflow), 32'd1);
`endif
        checkModel("ovf");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1);
            checkOutput("drain_pv",   32'(pop_valid), 32'd1);
            checkOutput("drain_data", 32'(pop_data),  32'(i));
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("drain_level", 32'(level), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
        err_clr = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0);
        err_clr = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        checkOutput("errclr_ovf", 32'(overflow), 32'd0);
`endif

        $display("[TB] simultaneous push and pop");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h5000 + 16'(i), 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h5FFF, 1'b1);
        checkOutput("sim5_level", 32'(level),     32'd5);
        checkOutput("sim5_pv",    32'(pop_valid), 32'd1);
        checkOutput("sim5_pd",    32'(pop_data),  32'h5000);
        checkModel("sim5");
        drainAll("sim5_drain");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 16'h6000 + 16'(i), 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'h6FFF, 1'b1);
        checkOutput("simfull_level", 32'(level),    32'd15);
        checkOutput("simfull_pd",    32'(pop_data), 32'h6000);
        checkOutput("simfull_we",    32'(ram_we_0), 32'd0);
        checkModel("simfull");
        drainAll("simfull_drain");

        $display("[TB] random traffic across pointer wrap");
        pushed = 0;
        cyc    = 0;
        while ((pushed < 40 || mq.size() > 0) && cyc < 2000) begin
            logic p;
            logic r;
            logic [15:0] d;
            p = (pushed < 40) && ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) != 0);
            d = 16'($urandom);
            if (p && mq.size() < 16) pushed++;
            applyStimulus(p, d, r);
            checkModel("rand");
            cyc++;
        end
        checkOutput("rand_done", 32'(cyc < 2000), 32'd1);

        $display("[TB] reset during a write cycle");
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 16'hCAFE, 1'b0);
        checkOutput("rstw_we_before", 32'(ram_we_0), 32'd1);
        push = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_we_async", 32'(ram_we_0), 32'd0);
        checkOutput("rstw_cs_async", 32'(ram_cs_0), 32'd0);
        checkOutput("rstw_level",    32'(level),    32'd0);
        modelReset();
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0);
        checkOutput("rstw_empty_after", 32'(empty), 32'd1);
        checkOutput("rstw_level_after", 32'(level), 32'd0);
        checkModel("rstw");
        applyStimulus(1'b1, 16'h0BAD, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("rstw_repush_pd", 32'(pop_data), 32'h0BAD);
        checkModel("rstw_repush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Controller for the 16x16 dual-port asynchronous RAM used as the filter's synchronous FIFO storage. It is the initiator on both RAM ports: port 0 is write-only and port 1 is read-only. It owns the pointers, level and flags, and presents a push/pop interface to the filter datapath. All RAM control and address outputs are registered, so the RAM sees glitch-free cs/we.

Parameters:
DATA_W, 16, word width; must match RAM data width
ADDR_W, 4, RAM address width; DEPTH = 1<<ADDR_W (derived localparam, 16)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  write request
push_data  in  DATA_W  write word
full  out  1  no push accepted this cycle
pop  in  1  read request
pop_data  out  DATA_W  read word, registered
pop_valid  out  1  one-cycle pulse: pop_data updated
empty  out  1  no pop accepted this cycle
level  out  ADDR_W+1  occupancy, 0..DEPTH, includes in-flight write
ram_address_0  out  ADDR_W  RAM port 0 address
ram_data_0  out  DATA_W  drives RAM data_0; port 0 is never read, so there is no contention
ram_cs_0  out  1  port 0 chip select
ram_we_0  out  1  port 0 write enable
ram_oe_0  out  1  tied 0
ram_address_1  out  ADDR_W  RAM port 1 address = rd_ptr
ram_data_1  in  DATA_W  RAM read data (combinational from ram_address_1)
ram_cs_1  out  1  tied 1
ram_we_1  out  1  tied 0
ram_oe_1  out  1  tied 1

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr, level = 0.
  - ram_cs_0, ram_we_0 = 0; ram_address_0, ram_data_0 = 0.
  - pop_data = 0; pop_valid = 0.
  - Result: full = 0, empty = 1.
  - RAM contents are not cleared.
  - Reset during a write cycle drops ram_we_0 immediately; that entry is discarded.
- Push accept: acc_w = push && !full.
  - On acc_w at edge: ram_address_0 <= wr_ptr, ram_data_0 <= push_data, ram_cs_0 <= 1, ram_we_0 <= 1.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
  - Without acc_w: ram_cs_0/ram_we_0 <= 0; address and data hold.
  - we is high for exactly one cycle per accepted push. Back-to-back pushes keep we high with the address changing at the edge.
- Pop accept: acc_r = pop && !empty.
  - On acc_r at edge: pop_data <= ram_data_1 (sampled at rd_ptr), pop_valid <= 1, rd_ptr <= rd_ptr+1 (wrap).
  - Otherwise pop_valid <= 0 and pop_data holds.
- Level: level <= level + acc_w - acc_r; simultaneous accepts leave it unchanged.
- Flags (combinational from registers):
  - full = (level == DEPTH).
  - empty = ((level - ram_we_0) == 0); this counts committed words only.
- Latency:
  - A push accepted in cycle N is written to RAM in N+1 and becomes poppable in N+2.
  - A pop accepted in cycle N gives pop_valid and pop_data in N+1.
- Hazards:
  - rd_ptr always addresses a committed word, so a read never overlaps the pending write slot.
  - Push while full is ignored even if a pop is accepted the same cycle; the full state is sampled before the pop.
  - Pop while empty is ignored even if a push is accepted the same cycle.
- Wrap: both pointers roll over freely. full/empty come from level, never from pointer compare.

Optional Feature:
SYNC_FIFO_ERR_EN
- With it, three extra ports:
  - err_clr in 1.
  - overflow out 1: sticky, set on push && full.
  - underflow out 1: sticky, set on pop && empty.
  - Both cleared by err_clr (clear wins over set in the same cycle); both reset to 0.
- Without it, these ports do not exist and illegal requests are silently dropped.

Decomposition:
- Package sync_fifo_pkg: DATA_W/ADDR_W defaults, DEPTH constant, tie-off constants for the RAM control levels.
- One sub-module: sync_fifo_ptr, an ADDR_W-bit wrapping pointer with enable, instantiated twice (wr_ptr, rd_ptr).

Test Plan:
- Reset then idle: level=0, empty=1, full=0, ram_we_0=0, pop_valid=0 for 10 cycles.
- Push 0x1234 at cycle 0:
  - cycle 1: ram_we_0=1, ram_address_0=0, ram_data_0=0x1234, empty=1.
  - cycle 2: empty=0.
  - Then pop: next cycle pop_valid=1, pop_data=0x1234.
- Fill 0x0000..0x000F in 16 back-to-back pushes:
  - full=1, level=16.
  - A 17th push of 0xFFFF is ignored (overflow=1 with SYNC_FIFO_ERR_EN).
  - Draining returns 0x0000..0x000F in order, then empty=1.
- Wrap: push/pop 40 words with random gaps; data order preserved across pointer rollover and level matches the reference count every cycle.
- Simultaneous push+pop at level=5: level stays 5 and the popped word is the oldest. At full, the same pair only pops, so level=15.
- Assert rst_n low while ram_we_0=1: ram_we_0 drops asynchronously; after release, level=0 and empty=1.
